// File: rtl/regfile_dump_pkg.sv
// Shared CPU definitions for the register-file dump engine: widths and the
// dump state enumeration.
package regfile_dump_pkg;

    localparam int DUMP_XLEN   = 32;
    localparam int DUMP_ADDR_W = 5;
    localparam int DUMP_NREGS  = 1 << DUMP_ADDR_W;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } dump_state_e;

endpackage

// File: rtl/register_file.sv
// Integer register file with one write port and one combinational read port;
// x0 always reads as zero.
module register_file
    import regfile_dump_pkg::*;
#(
    parameter int XLEN   = DUMP_XLEN,
    parameter int ADDR_W = DUMP_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [XLEN-1:0]   wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [XLEN-1:0]   rdata
);

    logic [XLEN-1:0] regs_q [1<<ADDR_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < (1 << ADDR_W); i++) begin
                regs_q[i] <= '0;
            end
        end else if (we && (waddr != '0)) begin
            regs_q[waddr] <= wdata;
        end
    end

    assign rdata = (raddr == '0) ? '0 : regs_q[raddr];

endmodule

// File: rtl/regfile_dump.sv
// Streams a wrapping range of register-file entries out over a valid/ready
// port, one beat per cycle when the consumer keeps up.
//
//   state    | meaning
//   ST_IDLE  | waiting for start; outputs quiet
//   ST_RUN   | reading registers and loading output beats
//   ST_DRAIN | final beat loaded, waiting for it to be accepted
module regfile_dump
    import regfile_dump_pkg::*;
#(
    parameter int XLEN   = DUMP_XLEN,
    parameter int ADDR_W = DUMP_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] first_reg,
    input  logic [ADDR_W-1:0] last_reg,
    output logic [ADDR_W-1:0] rf_read_reg,
    input  logic [XLEN-1:0]   rf_read_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_reg,
    output logic [XLEN-1:0]   out_data,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    dump_state_e       state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [ADDR_W-1:0] last_q, last_d;
    logic              out_valid_q, out_valid_d;
    logic [ADDR_W-1:0] out_reg_q, out_reg_d;
    logic [XLEN-1:0]   out_data_q, out_data_d;
    logic              out_last_q, out_last_d;
    logic              done_q, done_d;

    logic xfer;
    logic slot_free;

    assign xfer      = out_valid_q & out_ready;
    assign slot_free = ~out_valid_q | out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            last_q      <= '0;
            out_valid_q <= 1'b0;
            out_reg_q   <= '0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            last_q      <= last_d;
            out_valid_q <= out_valid_d;
            out_reg_q   <= out_reg_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            done_q      <= done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        last_d      = last_q;
        out_valid_d = out_valid_q;
        out_reg_d   = out_reg_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        done_d      = 1'b0;

        if (abort) begin
            state_d     = ST_IDLE;
            out_valid_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        last_d  = last_reg;
                        cnt_d   = first_reg;
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    // Load whenever the output slot empties this edge.
                    if (slot_free) begin
                        out_valid_d = 1'b1;
                        out_data_d  = rf_read_data;
                        out_reg_d   = cnt_q;
                        out_last_d  = (cnt_q == last_q);
                        if (cnt_q == last_q) begin
                            state_d = ST_DRAIN;
                        end else begin
                            cnt_d = cnt_q + ADDR_W'(1);
                        end
                    end
                end
                ST_DRAIN: begin
                    if (xfer) begin
                        out_valid_d = 1'b0;
                        done_d      = 1'b1;
                        state_d     = ST_IDLE;
                    end
                end
                default: begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b0;
                end
            endcase
        end
    end

    assign rf_read_reg = (state_q == ST_RUN) ? cnt_q : '0;
    assign busy        = (state_q != ST_IDLE);
    assign out_valid   = out_valid_q;
    assign out_reg     = out_reg_q;
    assign out_data    = out_data_q;
    assign out_last    = out_last_q;
    assign done        = done_q;

endmodule

// File: tb/tb_regfile_dump.sv
// Self-checking bench for regfile_dump: a register file beside the dumper and
// a plain-array reference of its contents used to predict every beat.
module tb_regfile_dump;
    import regfile_dump_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, abort, out_ready, we;
    logic [4:0]  first_reg, last_reg, rf_read_reg, out_reg, waddr;
    logic [31:0] rf_read_data, out_data, wdata;
    logic        out_valid, out_last, busy, done;

    int total = 0;
    int bad   = 0;
    logic [31:0] ref_rf [32];

    always #5 clk = ~clk;

    register_file #(.XLEN(32), .ADDR_W(5)) u_rf (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (we),
        .waddr (waddr),
        .wdata (wdata),
        .raddr (rf_read_reg),
        .rdata (rf_read_data)
    );

    regfile_dump #(.XLEN(32), .ADDR_W(5)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .abort        (abort),
        .first_reg    (first_reg),
        .last_reg     (last_reg),
        .rf_read_reg  (rf_read_reg),
        .rf_read_data (rf_read_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_reg      (out_reg),
        .out_data     (out_data),
        .out_last     (out_last),
        .busy         (busy),
        .done         (done)
    );

    task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        we = 1'b1; waddr = a; wdata = d;
        @(negedge clk);
        we = 1'b0;
        if (a != 5'd0) ref_rf[a] = d;
    endtask

    task automatic clear_model();
        for (int i = 0; i < 32; i++) ref_rf[i] = 32'h0;
    endtask

    // Runs one dump of first..last (wrapping) and checks every beat against the
    // reference array. ready_pct is the chance per cycle the consumer accepts;
    // inject_at (>0) pulses a stray start with first=9 at that cycle.
    task automatic do_dump(input logic [4:0] f, input logic [4:0] l,
                           input int ready_pct, input int inject_at);
        int          n;
        int          cyc;
        logic [4:0]  exp_q [$];
        logic [4:0]  e;
        logic        rdy;
        logic        held;
        logic [4:0]  h_reg;
        logic [31:0] h_data;
        logic        h_last;
        n = int'(5'(l - f)) + 1;
        for (int i = 0; i < n; i++) exp_q.push_back(5'(f + 5'(i)));
        held = 1'b0; h_reg = '0; h_data = '0; h_last = 1'b0;

        @(negedge clk);
        first_reg = f; last_reg = l; start = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0; first_reg = 5'($urandom); last_reg = 5'($urandom);
        total++;
        if (out_valid !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL run_entry: valid=%b busy=%b, want valid=0 busy=1", out_valid, busy);
        end

        cyc = 0;
        while (exp_q.size() > 0 && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                total++;
                if (out_valid !== 1'b1) begin
                    bad++;
                    $display("FAIL first_beat_latency: valid=%b want 1", out_valid);
                end
            end
            if (cyc == inject_at) begin
                start = 1'b1; first_reg = 5'd9; last_reg = 5'd12;
            end else begin
                start = 1'b0;
            end
            if (held) begin
                total++;
                if (out_valid !== 1'b1 || out_reg !== h_reg || out_data !== h_data || out_last !== h_last) begin
                    bad++;
                    $display("FAIL hold_stable: got v=%b reg=%0d data=%h last=%b want v=1 reg=%0d data=%h last=%b",
                             out_valid, out_reg, out_data, out_last, h_reg, h_data, h_last);
                end
            end
            rdy = ($urandom_range(99) < ready_pct);
            out_ready = rdy;
            held = 1'b0;
            if (out_valid === 1'b1) begin
                if (rdy) begin
                    e = exp_q.pop_front();
                    total++;
                    if (out_reg !== e || out_data !== ref_rf[e] || out_last !== (exp_q.size() == 0)) begin
                        bad++;
                        $display("FAIL beat: got reg=%0d data=%h last=%b want reg=%0d data=%h last=%b",
                                 out_reg, out_data, out_last, e, ref_rf[e], (exp_q.size() == 0));
                    end
                end else begin
                    held = 1'b1; h_reg = out_reg; h_data = out_data; h_last = out_last;
                end
            end
        end
        start = 1'b0;
        if (exp_q.size() > 0) begin
            total++; bad++;
            $display("FAIL dump_timeout: %0d beats missing after %0d cycles", exp_q.size(), cyc);
            return;
        end
        if (ready_pct >= 100) begin
            total++;
            if (cyc != n) begin
                bad++;
                $display("FAIL throughput: took %0d cycles want %0d", cyc, n);
            end
        end
        @(negedge clk);
        total++;
        if (done !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || rf_read_reg !== 5'd0) begin
            bad++;
            $display("FAIL done_pulse: done=%b valid=%b busy=%b rd=%0d want 1 0 0 0",
                     done, out_valid, busy, rf_read_reg);
        end
        @(negedge clk);
        total++;
        if (done !== 1'b0) begin
            bad++;
            $display("FAIL done_width: done=%b want 0", done);
        end
    endtask

    task automatic test_reset();
        total++;
        if (out_valid !== 0 || out_reg !== 0 || out_data !== 0 || out_last !== 0 ||
            busy !== 0 || done !== 0 || rf_read_reg !== 0) begin
            bad++;
            $display("FAIL reset_state: v=%b reg=%0d data=%h last=%b busy=%b done=%b rd=%0d want all 0",
                     out_valid, out_reg, out_data, out_last, busy, done, rf_read_reg);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL idle_after_reset: busy=%b valid=%b want 0 0", busy, out_valid);
        end
    endtask

    task automatic test_directed();
        write_reg(5'd1, 32'hDEADBEEF);
        write_reg(5'd2, 32'h12345678);
        do_dump(5'd0, 5'd3, 100, 0);
        do_dump(5'd30, 5'd1, 100, 0);
    endtask

    task automatic test_backpressure();
        // Beat 1 is stalled for exactly three cycles.
        int          cyc;
        int          beats;
        logic [4:0]  e;
        @(negedge clk);
        first_reg = 5'd0; last_reg = 5'd3; start = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        beats = 0; cyc = 0;
        while (beats < 4 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (out_valid === 1'b1 && out_reg === 5'd1 && cyc >= 2 && cyc <= 5) begin
                total++;
                if (out_data !== 32'hDEADBEEF) begin
                    bad++;
                    $display("FAIL stall_data: got %h want deadbeef", out_data);
                end
            end
            out_ready = !(cyc >= 2 && cyc <= 4);
            if (out_valid === 1'b1 && out_ready) begin
                e = 5'(beats);
                total++;
                if (out_reg !== e || out_data !== ref_rf[e]) begin
                    bad++;
                    $display("FAIL stall_beat: got reg=%0d data=%h want reg=%0d data=%h",
                             out_reg, out_data, e, ref_rf[e]);
                end
                beats++;
            end
        end
        total++;
        if (beats != 4 || cyc != 7) begin
            bad++;
            $display("FAIL stall_count: beats=%0d cycles=%0d want 4 7", beats, cyc);
        end
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_abort();
        @(negedge clk);
        first_reg = 5'd0; last_reg = 5'd7; start = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int b = 0; b < 2; b++) begin
            @(negedge clk);
            total++;
            if (out_valid !== 1'b1 || out_reg !== 5'(b) || out_data !== ref_rf[b]) begin
                bad++;
                $display("FAIL abort_prebeat: got v=%b reg=%0d data=%h want v=1 reg=%0d data=%h",
                         out_valid, out_reg, out_data, b, ref_rf[b]);
            end
        end
        abort = 1'b1;
        start = 1'b1; first_reg = 5'd20; last_reg = 5'd21;
        @(negedge clk);
        abort = 1'b0; start = 1'b0;
        total++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL abort_stop: valid=%b busy=%b done=%b want 0 0 0", out_valid, busy, done);
        end
        @(negedge clk);
        total++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL abort_nodone: done=%b busy=%b want 0 0", done, busy);
        end
        write_reg(5'd5, 32'hA5A5_0005);
        do_dump(5'd5, 5'd5, 100, 0);
    endtask

    task automatic test_ignore_start();
        do_dump(5'd2, 5'd8, 100, 2);
        do_dump(5'd28, 5'd4, 70, 3);
    endtask

    task automatic test_random();
        for (int i = 1; i < 32; i++) write_reg(5'(i), $urandom);
        for (int k = 0; k < 8; k++) begin
            do_dump(5'($urandom), 5'($urandom), 30 + int'($urandom_range(70)), 0);
        end
    endtask

    task automatic test_reset_mid_run();
        @(negedge clk);
        first_reg = 5'd3; last_reg = 5'd20; start = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (out_valid !== 0 || out_reg !== 0 || out_data !== 0 || out_last !== 0 ||
            busy !== 0 || done !== 0 || rf_read_reg !== 0) begin
            bad++;
            $display("FAIL async_reset: v=%b reg=%0d data=%h last=%b busy=%b done=%b rd=%0d want all 0",
                     out_valid, out_reg, out_data, out_last, busy, done, rf_read_reg);
        end
        clear_model();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_nodone: done=%b busy=%b want 0 0", done, busy);
        end
        write_reg(5'd7, 32'hCAFE_F00D);
        write_reg(5'd8, 32'h0BAD_CAFE);
        do_dump(5'd6, 5'd9, 100, 0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; out_ready = 1'b0; we = 1'b0;
        first_reg = '0; last_reg = '0; waddr = '0; wdata = '0;
        clear_model();
        #12;
        test_reset();
        test_directed();
        test_backpressure();
        test_abort();
        test_ignore_start();
        test_random();
        test_reset_mid_run();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
